// File: rtl/log_capture_ctrl.sv
// rtl/log_capture_ctrl.sv - sample-log BRAM sequencer: triggered decimated capture and valid/ready dump
module log_capture_ctrl #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int NB_DECIM        = 8
) (
  input  logic                       clk,
  input  logic                       i_rstn,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_trig_en,
  input  logic                       i_trig,
  input  logic [NB_DECIM-1:0]        i_decim,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_last_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] i_sample,
  input  logic                       i_dump,
  output logic                       o_mem_we,
  output logic [BRAM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [BRAM_DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [BRAM_DATA_WIDTH-1:0] i_mem_rdata,
  output logic [BRAM_DATA_WIDTH-1:0] o_rd_data,
  output logic                       o_rd_valid,
  input  logic                       i_rd_ready,
  output logic                       o_mem_full,
  output logic                       o_busy,
  output logic [2:0]                 o_state
);

  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int DW = BRAM_DATA_WIDTH;
  localparam logic [AW-1:0]       ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [NB_DECIM-1:0] DECIM_ONE = {{(NB_DECIM-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_CAPTURE   = 3'd2,
    S_FULL      = 3'd3,
    S_DUMP_ADDR = 3'd4,
    S_DUMP_WAIT = 3'd5,
    S_DUMP_OUT  = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       last_addr_q, last_addr_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [NB_DECIM-1:0] decim_q, decim_d;
  logic [NB_DECIM-1:0] dcnt_q, dcnt_d;
  logic                trig_en_q, trig_en_d;
  logic                mem_we_q, mem_we_d;
  logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]       rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                mem_full_q, mem_full_d;
  logic                busy_q, busy_d;
  logic                take;
  logic                dump_next;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    last_addr_d = last_addr_q;
    decim_d     = decim_q;
    dcnt_d      = dcnt_q;
    trig_en_d   = trig_en_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    mem_full_d  = mem_full_q;
    take        = 1'b0;

    if (i_abort) begin
      // Abort outranks everything, including a sample due this cycle.
      state_d    = S_IDLE;
      rd_valid_d = 1'b0;
      mem_full_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FULL: begin
          if (i_start) begin
            last_addr_d = i_last_addr;
            decim_d     = i_decim;
            trig_en_d   = i_trig_en;
            wr_ptr_d    = '0;
            dcnt_d      = '0;
            mem_full_d  = 1'b0;
            state_d     = S_ARM;
          end else if (i_dump && (state_q == S_FULL)) begin
            rd_ptr_d = '0;
            state_d  = S_DUMP_ADDR;
          end
        end
        S_ARM: begin
          if (!trig_en_q || i_trig) begin
            dcnt_d  = '0;
            state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + DECIM_ONE;
          if (dcnt_q == '0) begin
            take        = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = i_sample;
            // Pointer parks on last_addr so a full-depth capture never wraps.
            if (wr_ptr_q == last_addr_q) begin
              mem_full_d = 1'b1;
              state_d    = S_FULL;
            end else begin
              wr_ptr_d = wr_ptr_q + ADDR_ONE;
            end
          end
        end
        S_DUMP_ADDR: state_d = S_DUMP_WAIT;
        S_DUMP_WAIT: begin
          rd_data_d  = i_mem_rdata;
          rd_valid_d = 1'b1;
          state_d    = S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (i_rd_ready) begin
            rd_valid_d = 1'b0;
            if (rd_ptr_q == last_addr_q) begin
              state_d = S_FULL;
            end else begin
              rd_ptr_d = rd_ptr_q + ADDR_ONE;
              state_d  = S_DUMP_ADDR;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    dump_next = (state_d == S_DUMP_ADDR) || (state_d == S_DUMP_WAIT) ||
                (state_d == S_DUMP_OUT);
    busy_d    = dump_next || (state_d == S_ARM) || (state_d == S_CAPTURE);

    // The write address is the pre-increment pointer of the sample just taken.
    if (take) begin
      mem_addr_d = wr_ptr_q;
    end else if (dump_next) begin
      mem_addr_d = rd_ptr_d;
    end else begin
      mem_addr_d = wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_addr_q <= '0;
      mem_addr_q  <= '0;
      decim_q     <= '0;
      dcnt_q      <= '0;
      trig_en_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      mem_full_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      last_addr_q <= last_addr_d;
      mem_addr_q  <= mem_addr_d;
      decim_q     <= decim_d;
      dcnt_q      <= dcnt_d;
      trig_en_q   <= trig_en_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      mem_full_q  <= mem_full_d;
      busy_q      <= busy_d;
    end
  end

  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_mem_full  = mem_full_q;
  assign o_busy      = busy_q;
  assign o_state     = state_q;

endmodule
